// File: rtl/uart_pkg.sv
// Shared 8N1 UART definitions, used by both receiver and transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int   UART_DATA_W    = 8;
    localparam logic UART_STOP_BIT  = 1'b1;
    localparam logic UART_START_BIT = 1'b0;

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for a single asynchronous bit.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values: shift the raw input through two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchroniser flops, reset to the line's idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronise rxd, find the start edge, sample each bit at its centre.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rxd,
    output logic [UART_DATA_W-1:0] data,
    output logic                   valid,
    output logic                   frame_err,
    output logic                   busy
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int HALF  = CLK_DIV / 2;

    localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLK_DIV - 1);

    logic rxd_s;

    uart_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rxd),
        .q     (rxd_s)
    );

    uart_state_t            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [UART_DATA_W-1:0] sh_q, sh_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    // Previous synchronised sample, for falling-edge detection.
    logic                   rxd_prev_q, rxd_prev_d;

    // Next-state and datapath: count bit periods, sample at bit centres.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        sh_d       = sh_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        rxd_prev_d = rxd_s;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rxd_prev_q && !rxd_s) begin
                    state_d = START;
                end
            end
            START: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_HALF_M1) begin
                    cnt_d = '0;
                    if (rxd_s == UART_START_BIT) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    sh_d  = {rxd_s, sh_q[UART_DATA_W-1:1]};
                    cnt_d = '0;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rxd_s == UART_STOP_BIT) begin
                        data_d  = sh_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Receiver state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            sh_q       <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            rxd_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sh_q       <= sh_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            rxd_prev_q <= rxd_prev_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a line driver plus an expected-pulse scoreboard.
module tb_uart_rx;

    localparam int CLK_DIV = 16;
    localparam int HALF    = CLK_DIV / 2;
    localparam int TCLK    = 100;
    localparam int TBIT    = CLK_DIV * TCLK;
    // Posedges from the line's fall to the edge that registers valid/frame_err.
    localparam longint PULSE_LAT = 3 + HALF + 9 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    typedef struct {
        logic [7:0] b;
        bit         err;
        longint     cyc;
        bit         chk_t;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] last_good = 8'h00;
    longint     cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    uart_rx #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #(TCLK / 2) clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every pulse must match the oldest expected frame.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] exp_data;
        if (rst_n && (valid || frame_err)) begin
            n_checks++;
            if (valid && frame_err) begin
                n_fail++;
                $display("FAIL both_pulses valid=%b frame_err=%b required not both high", valid, frame_err);
            end
            if (expq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse at cycle %0d valid=%b frame_err=%b data=%h, none required", cyc, valid, frame_err, data);
            end else begin
                e = expq.pop_front();
                exp_data = e.err ? last_good : e.b;
                if (!e.err) last_good = e.b;
                if (valid !== !e.err || frame_err !== e.err) begin
                    n_fail++;
                    $display("FAIL pulse_kind valid=%b frame_err=%b required valid=%b frame_err=%b", valid, frame_err, !e.err, e.err);
                end
                n_checks++;
                if (data !== exp_data) begin
                    n_fail++;
                    $display("FAIL pulse_data got %h required %h", data, exp_data);
                end
                if (e.chk_t) begin
                    n_checks++;
                    if (cyc !== e.cyc) begin
                        n_fail++;
                        $display("FAIL pulse_time got cycle %0d required %0d", cyc, e.cyc);
                    end
                end
            end
        end
    end

    // Drive one frame; bit_t is the bit period in time units.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_t,
                              input bit resync, input bit chk_t);
        exp_t e;
        if (resync) begin
            @(posedge clk);
            #1;
        end
        e.b     = b;
        e.err   = (stop == 1'b0);
        e.cyc   = cyc + PULSE_LAT;
        e.chk_t = chk_t;
        expq.push_back(e);
        rxd = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #(bit_t);
        end
        rxd = stop;
        #(bit_t);
    endtask

    task automatic drain(input string name);
        repeat (2 * CLK_DIV * 10) @(posedge clk);
        n_checks++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing_pulses got %0d outstanding required 0", name, expq.size());
        end
        expq.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rxd   = 1'b1;
        #(3 * TCLK + 7);
        n_checks++;
        if (data !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got data=%h valid=%b ferr=%b busy=%b required 00 0 0 0", data, valid, frame_err, busy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_single();
        send_frame(8'hA5, 1'b1, TBIT, 1'b1, 1'b1);
        drain("single");
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'h3C;
        send_frame(bytes[0], 1'b1, TBIT, 1'b1, 1'b1);
        for (int i = 1; i < 3; i++) send_frame(bytes[i], 1'b1, TBIT, 1'b0, 1'b1);
        drain("b2b");
    endtask

    task automatic test_glitch();
        @(posedge clk);
        #1;
        rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (HALF - 2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_busy_before got %b required 1", busy);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_busy_after got %b required 0", busy);
        end
        drain("glitch");
    endtask

    task automatic test_frame_err();
        send_frame(8'h81, 1'b0, TBIT, 1'b1, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL break_busy got %b required 0", busy);
        end
        rxd = 1'b1;
        repeat (2 * CLK_DIV) @(posedge clk);
        drain("ferr");
        send_frame(8'h66, 1'b1, TBIT, 1'b1, 1'b1);
        drain("ferr_recover");
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'h5A;
        @(posedge clk);
        #1;
        rxd = 1'b0;
        #(TBIT);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            #(TBIT);
        end
        rxd = b[4];
        #(TBIT / 2 + 30);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_busy got %b required 1", busy);
        end
        rst_n = 1'b0;
        #5;
        n_checks++;
        if (data !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_reset got data=%h valid=%b ferr=%b busy=%b required 00 0 0 0", data, valid, frame_err, busy);
        end
        expq.delete();
        last_good = 8'h00;
        rxd = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2 * CLK_DIV * 10) @(posedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_no_restart busy got %b required 0", busy);
        end
        send_frame(8'h12, 1'b1, TBIT, 1'b1, 1'b1);
        drain("after_reset");
    endtask

    task automatic test_baud();
        send_frame(8'hC3, 1'b1, TBIT * 103 / 100, 1'b1, 1'b0);
        drain("baud_slow");
        send_frame(8'hC3, 1'b1, TBIT * 97 / 100, 1'b1, 1'b0);
        drain("baud_fast");
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            repeat ($urandom_range(0, 30)) @(posedge clk);
            send_frame(8'($urandom), 1'b1, TBIT, 1'b1, 1'b1);
        end
        drain("random");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        test_baud();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, the receive half of the team's 8N1 UART. It synchronises the `rxd` pin into the `clk` domain and detects the start bit. Each bit is sampled at its centre using an internal bit-period counter. Each received byte is presented with a one-cycle `valid` pulse; a bad stop bit instead raises a one-cycle `frame_err` pulse. Frame format matches the transmitter: start bit 0, 8 data bits LSB first, stop bit 1, idle line high.

## Interface
- `CLK_DIV`, default 16: `clk` cycles per bit. Must equal the transmitter's `clk` cycles per `clk_uart` pulse. Legal range 4..65535.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `rxd`  input  1  serial line, asynchronous to `clk`, idle high.
- `data`  output  8  last correctly received byte; holds until the next good frame.
- `valid`  output  1  one-cycle pulse: `data` updated this cycle.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled 0; `data` unchanged.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- Input path: 2-flop synchroniser gives `rxd_s`. A third flop `rxd_d` holds the previous `rxd_s`. All three flops reset to 1.
- Constants: `HALF = CLK_DIV/2` (floor). Bit counter `cnt` is `$clog2(CLK_DIV)` bits wide. Bit index `idx` is 3 bits. Shift register `sh` is 8 bits.
- FSM states and transitions:
  - IDLE: on `rxd_d==1 && rxd_s==0` (falling edge), go to START and set `cnt` to 0.
  - START: `cnt` increments each cycle. At `cnt==HALF-1`, sample `rxd_s`:
    - If 0, go to DATA with `cnt` and `idx` set to 0.
    - If 1, the start bit was a glitch; return to IDLE with no pulse.
  - DATA: `cnt` increments each cycle. At `cnt==CLK_DIV-1`:
    - Sample `rxd_s` into `sh` MSB; `sh` shifts right.
    - Set `cnt` to 0 and increment `idx`.
    - After the sample at `idx==7`, go to STOP.
  - STOP: at `cnt==CLK_DIV-1`, sample `rxd_s`:
    - If 1, load `data` from `sh` and pulse `valid`.
    - If 0, pulse `frame_err`.
    - In both cases go to IDLE.
- IDLE is re-entered at the centre of the stop bit, so back-to-back frames (no idle gap) are received without loss.
- After a framing error or break (line held low), no new frame starts until `rxd_s` returns high and falls again. This follows from the edge detection.
- `valid` and `frame_err` are never high in the same cycle.
- No flow control or overrun detection. The consumer must accept `data` within one frame time.

## Timing
- Reset values:
  - State IDLE; `cnt`, `idx`, `sh` = 0.
  - `data`=8'h00, `valid`=0, `frame_err`=0, `busy`=0.
- Reset mid-frame aborts immediately with no pulse. The next frame is found only after a fresh falling edge following reset release.
- Let t0 be the clock edge on which the FSM leaves IDLE.
- Sample edges:
  - Start bit at t0+HALF.
  - Data bit i (i=0..7) at t0+HALF+(i+1)*CLK_DIV.
  - Stop bit at t0+HALF+9*CLK_DIV.
- `valid`/`frame_err` are registered on the stop-sample edge and high for exactly that one following cycle. `data` changes on the same edge as `valid` rises.
- Latency from the line's falling edge to t0: 3 cycles (2 synchroniser flops plus 1 edge-detect).
- `busy` rises at t0 and falls on the stop-sample edge.
- Tolerated baud mismatch: about ±4% at CLK_DIV=16, set by centre sampling.

## Structure
- Shared package `uart_pkg`:
  - `uart_state_t` enum {IDLE, START, DATA, STOP}.
  - `UART_DATA_W = 8`, `UART_STOP_BIT = 1'b1`, `UART_START_BIT = 1'b0`.
  - These constants are reused by the transmitter.
- One sub-module `uart_sync2`: generic 2-flop synchroniser with parameterised reset value (1 here). It is the only place `rxd` is sampled raw.

## Test plan
- Single frame: CLK_DIV=16, send 8'hA5 with correct timing -> exactly one `valid` pulse at t0+8+144, `data`=8'hA5, `frame_err` never high.
- Back-to-back frames: send 8'h00, 8'hFF, 8'h3C with no idle gap -> three `valid` pulses exactly 160 cycles apart, with data 00, FF, 3C in order.
- Glitch rejection: drive `rxd` low for 4 cycles then high -> FSM returns to IDLE, `busy` drops after HALF cycles, no pulse.
- Framing error: send 8'h81 with stop bit 0 -> one `frame_err` pulse, `data` keeps its prior value. With the line then held low for 40 cycles, no frame starts until `rxd` rises and falls again.
- Reset mid-frame: assert `rst_n` low during bit 4 of 8'h5A -> all outputs return to reset values asynchronously. A following clean frame 8'h12 is received correctly.
- Baud tolerance: transmit at +3% and -3% bit period with CLK_DIV=16 -> 8'hC3 is received correctly in both cases.
